// File: rtl/mandelbrot_pixel_scheduler.sv
// Frame sequencer for a pool of Mandelbrot depth/colour engines.
// Walks the frame in raster order, hands each pixel to the next free engine
// in round-robin order, and retires colours in raster order onto a
// valid/ready pixel stream.
module mandelbrot_pixel_scheduler #(
    parameter int FRAC        = 60,
    parameter int WORD_LENGTH = 64,
    parameter int NUM_ENGINES = 4,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic [WORD_LENGTH-1:0]    re_origin,
    input  logic [WORD_LENGTH-1:0]    im_origin,
    input  logic [WORD_LENGTH-1:0]    step,
    output logic [NUM_ENGINES-1:0]    eng_start,
    output logic [10:0]               eng_x,
    output logic [10:0]               eng_y,
    output logic [WORD_LENGTH-1:0]    eng_re_c,
    output logic [WORD_LENGTH-1:0]    eng_im_c,
    input  logic [NUM_ENGINES-1:0]    eng_done,
    input  logic [24*NUM_ENGINES-1:0] eng_color,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [10:0]               pix_x,
    output logic [10:0]               pix_y,
    output logic [23:0]               pix_color,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(NUM_ENGINES - 1);
    localparam logic [10:0]   LAST_X   = 11'(H_RES - 1);
    localparam logic [10:0]   LAST_Y   = 11'(V_RES - 1);

    // Reject parameter sets the coordinate counters and fixed point cannot represent.
    if (NUM_ENGINES < 1 || FRAC >= WORD_LENGTH || H_RES < 2 || H_RES > 2047 ||
        V_RES < 1 || V_RES > 2047) begin : g_bad_params
        $error("mandelbrot_pixel_scheduler: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} fsm_t;
    typedef enum logic [1:0] {FREE, BUSY, COLOR, HELD} slot_t;

    fsm_t                          state;
    slot_t                         slot_st    [NUM_ENGINES];
    logic [10:0]                   slot_x     [NUM_ENGINES];
    logic [10:0]                   slot_y     [NUM_ENGINES];
    logic [23:0]                   slot_color [NUM_ENGINES];
    logic [PW-1:0]                 issue_ptr;
    logic [PW-1:0]                 retire_ptr;
    logic [10:0]                   x_cnt;
    logic [10:0]                   y_cnt;
    logic signed [WORD_LENGTH-1:0] re_acc;
    logic signed [WORD_LENGTH-1:0] im_acc;
    logic signed [WORD_LENGTH-1:0] re_org;
    logic signed [WORD_LENGTH-1:0] step_r;

    logic [10:0]                   cur_x;
    logic [10:0]                   cur_y;
    logic signed [WORD_LENGTH-1:0] cur_re;
    logic signed [WORD_LENGTH-1:0] cur_im;
    logic signed [WORD_LENGTH-1:0] base_re;
    logic signed [WORD_LENGTH-1:0] cur_step;
    logic                          do_issue;
    logic                          last_issue;
    logic                          accept;
    logic                          retire_last;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Issue source: the accepted frame_start issues pixel (0,0) straight from
    // the origin inputs, so the first engine start follows one cycle later.
    always_comb begin
        cur_x    = x_cnt;
        cur_y    = y_cnt;
        cur_re   = re_acc;
        cur_im   = im_acc;
        base_re  = re_org;
        cur_step = step_r;
        if (state == IDLE) begin
            cur_x    = '0;
            cur_y    = '0;
            cur_re   = re_origin;
            cur_im   = im_origin;
            base_re  = re_origin;
            cur_step = step;
        end
        do_issue    = (state == IDLE && frame_start) ||
                      (state == RUN && slot_st[issue_ptr] == FREE);
        last_issue  = (cur_x == LAST_X) && (cur_y == LAST_Y);
        retire_last = (slot_x[retire_ptr] == LAST_X) && (slot_y[retire_ptr] == LAST_Y);
    end

    assign pix_valid = (slot_st[retire_ptr] == HELD);
    assign accept    = pix_valid && pix_ready;
    assign pix_x     = pix_valid ? slot_x[retire_ptr]     : '0;
    assign pix_y     = pix_valid ? slot_y[retire_ptr]     : '0;
    assign pix_color = pix_valid ? slot_color[retire_ptr] : '0;
    assign busy      = (state != IDLE);

    // Frame FSM, slot scoreboard, coordinate walk and registered issue bus.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state      <= IDLE;
            issue_ptr  <= '0;
            retire_ptr <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            eng_start  <= '0;
            eng_x      <= '0;
            eng_y      <= '0;
            eng_re_c   <= '0;
            eng_im_c   <= '0;
            frame_done <= 1'b0;
            for (int k = 0; k < NUM_ENGINES; k++) slot_st[k] <= FREE;
        end else begin
            eng_start  <= '0;
            frame_done <= 1'b0;

            // Done pulses only count for slots waiting on their engine; the
            // colour register in the engine is valid one cycle after done.
            for (int k = 0; k < NUM_ENGINES; k++) begin
                if (slot_st[k] == BUSY && eng_done[k]) begin
                    slot_st[k] <= COLOR;
                end else if (slot_st[k] == COLOR) begin
                    slot_st[k]    <= HELD;
                    slot_color[k] <= eng_color[24*k +: 24];
                end
            end

            if (accept) begin
                slot_st[retire_ptr] <= FREE;
                retire_ptr          <= ptr_next(retire_ptr);
            end

            if (do_issue) begin
                slot_st[issue_ptr]         <= BUSY;
                slot_x[issue_ptr]          <= cur_x;
                slot_y[issue_ptr]          <= cur_y;
                eng_start                  <= NUM_ENGINES'(1) << issue_ptr;
                eng_x                      <= cur_x;
                eng_y                      <= cur_y;
                eng_re_c                   <= cur_re;
                eng_im_c                   <= cur_im;
                issue_ptr                  <= ptr_next(issue_ptr);
                if (cur_x == LAST_X) begin
                    x_cnt  <= '0;
                    y_cnt  <= cur_y + 11'd1;
                    re_acc <= base_re;
                    im_acc <= cur_im - cur_step;
                end else begin
                    x_cnt  <= cur_x + 11'd1;
                    y_cnt  <= cur_y;
                    re_acc <= cur_re + cur_step;
                    im_acc <= cur_im;
                end
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state  <= RUN;
                        re_org <= re_origin;
                        step_r <= step;
                    end
                end
                RUN: begin
                    if (do_issue && last_issue) state <= DRAIN;
                end
                DRAIN: begin
                    if (accept && retire_last) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Scoreboard bench for mandelbrot_pixel_scheduler with a 4x2 frame and two
// behavioural engines of programmable latency.
module tb_mandelbrot_pixel_scheduler;

    localparam int H = 4;
    localparam int V = 2;
    localparam int NE = 2;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic [63:0]   re_origin, im_origin, step;
    logic [NE-1:0] eng_start;
    logic [10:0]   eng_x, eng_y;
    logic [63:0]   eng_re_c, eng_im_c;
    logic [NE-1:0] eng_done;
    logic [47:0]   eng_color;
    logic          pix_valid, pix_ready;
    logic [10:0]   pix_x, pix_y;
    logic [23:0]   pix_color;
    logic          busy, frame_done;

    mandelbrot_pixel_scheduler #(
        .FRAC(60), .WORD_LENGTH(64), .NUM_ENGINES(NE), .H_RES(H), .V_RES(V)
    ) dut (
        .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
        .re_origin(re_origin), .im_origin(im_origin), .step(step),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_re_c(eng_re_c), .eng_im_c(eng_im_c),
        .eng_done(eng_done), .eng_color(eng_color),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [63:0] re;
        logic [63:0] im;
    } pix_t;

    pix_t iss_q[$];
    pix_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_issued = 0;
    int n_accepted = 0;
    int n_frame_done = 0;
    int test_id = 0;
    int lat[NE];
    bit exp_last_done = 0;
    bit stall_prev = 0;
    logic [10:0] prev_x, prev_y;
    logic [23:0] prev_c;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (test %0d)", name, act, exp, test_id);
        end
    endtask

    function automatic logic [23:0] color_of(input logic [63:0] re, input logic [63:0] im,
                                             input logic [10:0] x, input logic [10:0] y);
        return re[63:40] ^ im[23:0] ^ {im[63:56], x[7:0], y[7:0]};
    endfunction

    // Behavioural engines: done <latency> cycles after start, colour one cycle after done.
    int          cnt[NE];
    bit          pend[NE];
    bit          act[NE];
    pix_t        held[NE];
    initial begin
        eng_done  = '0;
        eng_color = '0;
        for (int k = 0; k < NE; k++) begin cnt[k] = 0; pend[k] = 0; act[k] = 0; end
        forever begin
            @(posedge sysclk); #1;
            if (reset) begin
                eng_done = '0;
                for (int k = 0; k < NE; k++) begin cnt[k] = 0; pend[k] = 0; act[k] = 0; end
            end else begin
                for (int k = 0; k < NE; k++) begin
                    eng_done[k] = 1'b0;
                    if (pend[k]) begin
                        eng_color[24*k +: 24] = color_of(held[k].re, held[k].im, held[k].x, held[k].y);
                        pend[k] = 0;
                        act[k]  = 0;
                    end
                    if (cnt[k] > 0) begin
                        cnt[k]--;
                        if (cnt[k] == 0) begin eng_done[k] = 1'b1; pend[k] = 1; end
                    end
                    if (eng_start[k]) begin
                        chk("start_to_idle_engine", 64'(act[k]), 64'd0);
                        chk("outstanding_le_engines", 64'((n_issued - n_accepted) < NE), 64'd1);
                        n_issued++;
                        if (iss_q.size() == 0) begin
                            chk("unexpected_issue", 64'(eng_start), 64'd0);
                        end else begin
                            pix_t e;
                            e = iss_q.pop_front();
                            chk("issue_x", 64'(eng_x), 64'(e.x));
                            chk("issue_y", 64'(eng_y), 64'(e.y));
                            chk("issue_re", eng_re_c, e.re);
                            chk("issue_im", eng_im_c, e.im);
                        end
                        if (test_id == 1 && eng_x == 11'd3 && eng_y == 11'd0) begin
                            chk("t1_re_3_0", eng_re_c, 64'hF800_0000_0000_0000);
                            chk("t1_im_3_0", eng_im_c, 64'h1000_0000_0000_0000);
                        end
                        if (test_id == 1 && eng_x == 11'd0 && eng_y == 11'd1) begin
                            chk("t1_re_0_1", eng_re_c, 64'hE000_0000_0000_0000);
                            chk("t1_im_0_1", eng_im_c, 64'h0800_0000_0000_0000);
                        end
                        if (test_id == 6 && eng_x == 11'd2 && eng_y == 11'd0)
                            chk("t6_re_wrap", eng_re_c, 64'h4000_0000_0000_0000);
                        if (test_id == 6 && eng_x == 11'd1 && eng_y == 11'd1)
                            chk("t6_im_wrap", eng_im_c, 64'h8000_0000_0000_0001);
                        held[k].x  = eng_x;
                        held[k].y  = eng_y;
                        held[k].re = eng_re_c;
                        held[k].im = eng_im_c;
                        cnt[k] = lat[k];
                        act[k] = 1;
                    end
                end
            end
        end
    end

    // Output monitor: compares each accepted pixel against the scoreboard.
    always @(negedge sysclk) begin
        if (!reset) begin
            if (exp_last_done) begin
                chk("frame_done_after_last", 64'(frame_done), 64'd1);
                exp_last_done = 0;
            end else if (frame_done) begin
                chk("frame_done_spurious", 64'(frame_done), 64'd0);
            end
            if (frame_done) n_frame_done++;
            if (stall_prev) begin
                chk("stall_valid", 64'(pix_valid), 64'd1);
                chk("stall_x", 64'(pix_x), 64'(prev_x));
                chk("stall_y", 64'(pix_y), 64'(prev_y));
                chk("stall_color", 64'(pix_color), 64'(prev_c));
            end
            if (pix_valid && pix_ready) begin
                n_accepted++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", 64'(pix_valid), 64'd0);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    chk("pix_x", 64'(pix_x), 64'(e.x));
                    chk("pix_y", 64'(pix_y), 64'(e.y));
                    chk("pix_color", 64'(pix_color), 64'(color_of(e.re, e.im, e.x, e.y)));
                    if (exp_q.size() == 0) exp_last_done = 1;
                end
            end
            stall_prev = pix_valid && !pix_ready;
            prev_x = pix_x;
            prev_y = pix_y;
            prev_c = pix_color;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_eng_start"}, 64'(eng_start), 64'd0);
        chk({tag, "_eng_x"}, 64'(eng_x), 64'd0);
        chk({tag, "_eng_y"}, 64'(eng_y), 64'd0);
        chk({tag, "_eng_re_c"}, eng_re_c, 64'd0);
        chk({tag, "_eng_im_c"}, eng_im_c, 64'd0);
        chk({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
        chk({tag, "_pix_x"}, 64'(pix_x), 64'd0);
        chk({tag, "_pix_y"}, 64'(pix_y), 64'd0);
        chk({tag, "_pix_color"}, 64'(pix_color), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    task automatic run_frame(input int id, input logic [63:0] ro, input logic [63:0] io,
                             input logic [63:0] st, input int l0, input int l1,
                             input bit stall, input bit poke, input int abort_after);
        int fd0, acc0, i;
        test_id = id;
        lat[0] = l0;
        lat[1] = l1;
        // Reference coordinates use direct multiplication, not the incremental walk.
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                pix_t p;
                p.x  = 11'(x);
                p.y  = 11'(y);
                p.re = ro + 64'(x) * st;
                p.im = io - 64'(y) * st;
                iss_q.push_back(p);
                exp_q.push_back(p);
            end
        end
        fd0  = n_frame_done;
        acc0 = n_accepted;
        re_origin = ro;
        im_origin = io;
        step      = st;
        pix_ready = !stall;
        frame_start = 1'b1;
        @(posedge sysclk); #1;
        frame_start = 1'b0;
        chk("first_issue_latency", 64'(eng_start != '0), 64'd1);
        chk("busy_in_frame", 64'(busy), 64'd1);
        if (poke) begin
            repeat (3) @(posedge sysclk);
            #1;
            re_origin = 64'h1111_2222_3333_4444;
            im_origin = 64'h5555_6666_7777_8888;
            step      = 64'h0000_0000_0000_0123;
            frame_start = 1'b1;
            @(posedge sysclk); #1;
            frame_start = 1'b0;
        end
        if (stall) begin
            i = 0;
            while (!pix_valid && i < 200) begin @(posedge sysclk); #1; i++; end
            chk("stall_first_valid_seen", 64'(pix_valid), 64'd1);
            repeat (10) @(posedge sysclk);
            #1;
            pix_ready = 1'b1;
        end
        if (abort_after > 0) begin
            i = 0;
            while (n_accepted < acc0 + abort_after && i < 500) begin @(posedge sysclk); #1; i++; end
            chk("abort_accepts_reached", 64'(n_accepted - acc0), 64'(abort_after));
            reset = 1'b1;
            pix_ready = 1'b0;
            @(posedge sysclk); #1;
            check_reset_outputs("midreset");
            iss_q.delete();
            exp_q.delete();
            exp_last_done = 0;
            stall_prev = 0;
            n_issued = 0;
            n_accepted = 0;
            reset = 1'b0;
            pix_ready = 1'b1;
            repeat (30) @(posedge sysclk);
            #1;
            chk("no_frame_done_after_abort", 64'(n_frame_done), 64'(fd0));
            chk("idle_after_abort", 64'(busy), 64'd0);
            return;
        end
        i = 0;
        while (n_frame_done == fd0 && i < 2000) begin @(posedge sysclk); #1; i++; end
        chk("frame_done_count", 64'(n_frame_done - fd0), 64'd1);
        chk("busy_after_frame", 64'(busy), 64'd0);
        chk("all_issued", 64'(iss_q.size()), 64'd0);
        chk("all_retired", 64'(exp_q.size()), 64'd0);
        chk("pixels_in_frame", 64'(n_accepted - acc0), 64'(H * V));
        repeat (3) @(posedge sysclk);
        #1;
        chk("single_frame_done", 64'(n_frame_done - fd0), 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        re_origin = '0;
        im_origin = '0;
        step = '0;
        pix_ready = 1'b1;
        lat[0] = 5;
        lat[1] = 5;
        repeat (3) @(posedge sysclk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge sysclk); #1;

        // -2.0, +1.0, 0.5 in Q4.60
        run_frame(1, 64'hE000_0000_0000_0000, 64'h1000_0000_0000_0000,
                  64'h0800_0000_0000_0000, 5, 5, 0, 0, 0);
        run_frame(2, 64'hE000_0000_0000_0000, 64'h1000_0000_0000_0000,
                  64'h0800_0000_0000_0000, 20, 3, 0, 0, 0);
        run_frame(3, 64'hF000_0000_0000_0000, 64'h0400_0000_0000_0000,
                  64'h0100_0000_0000_0000, 5, 5, 1, 0, 0);
        run_frame(4, 64'hE000_0000_0000_0000, 64'h1000_0000_0000_0000,
                  64'h0800_0000_0000_0000, 5, 5, 0, 1, 0);
        run_frame(5, 64'hE000_0000_0000_0000, 64'h1000_0000_0000_0000,
                  64'h0800_0000_0000_0000, 5, 5, 0, 0, 3);
        run_frame(5, 64'hE800_0000_0000_0000, 64'h0C00_0000_0000_0000,
                  64'h0200_0000_0000_0000, 4, 6, 0, 0, 0);
        run_frame(6, 64'h4000_0000_0000_0000, 64'h0000_0000_0000_0001,
                  64'h8000_0000_0000_0000, 4, 7, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
